// File: rtl/inv_sbytes.sv
// inv_sbytes: AES inverse SubBytes over a 128-bit state.
//   LANES bytes are transformed per clock, so a transform takes 16/LANES
//   RUN cycles. The source state is captured on start, the result is
//   assembled in a work register and published to newdata in one step.
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   start    in   request to transform olddata (sampled in IDLE and DONE)
//   olddata  in   128-bit input state, byte i = bits [8i+7:8i]
//   busy     out  high while a transform is running
//   done     out  one-cycle pulse when newdata holds a new result
//   newdata  out  128-bit inverse-SubBytes result, same byte order
module inv_sbytes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] olddata,
  output logic         busy,
  output logic         done,
  output logic [127:0] newdata
);

  localparam int NGRP = 16 / LANES;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sbytes: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_src;
  logic [127:0]    r_work;
  logic [127:0]    w_work_next;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Current group's bytes replaced in a copy of the work register.
  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_next[(int'(r_cnt) * LANES + l) * 8 +: 8] =
        inv_sbox(r_src[(int'(r_cnt) * LANES + l) * 8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_work  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      newdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src   <= olddata;
            r_cnt   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_work_next;
          if (r_cnt == LAST) begin
            // Publish the whole result at once; counter stays at LAST.
            newdata <= w_work_next;
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            r_src   <= olddata;
            r_cnt   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbytes.sv
// Testbench for inv_sbytes: five instances (LANES = 1, 2, 4, 8, 16) share
// the stimulus; the LANES=4 instance (index 2) is the main subject.
// Golden values come from a forward S-box built from field arithmetic and
// inverted as a lookup table.
module tb_inv_sbytes;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] olddata;
  logic         busy_s [5];
  logic         done_s [5];
  logic [127:0] nd_s   [5];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] inv_tab [256];

  genvar k;
  generate
    for (k = 0; k < 5; k++) begin : g_dut
      inv_sbytes #(.LANES(1 << k)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .olddata (olddata),
        .busy    (busy_s[k]),
        .done    (done_s[k]),
        .newdata (nd_s[k])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial product reduced by the AES polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] fwd(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int z = 1; z < 256; z++) if (gmul(x, 8'(z)) == 8'h01) y = 8'(z);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[d[i*8 +: 8]];
    return r;
  endfunction

  task automatic xact(input logic [127:0] d, output int lat);
    olddata = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_s[2]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    logic [127:0] kat_in, kat_exp, a, b, d;
    int lat, first, second, ndone;
    int lat_s [5];
    int cnt_s [5];

    for (int x = 0; x < 256; x++) inv_tab[fwd(8'(x))] = 8'(x);

    rst = 1'b1;
    start = 1'b0;
    olddata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 128'(busy_s[2]), 128'd0);
    chk("reset_done", 128'(done_s[2]), 128'd0);
    chk("reset_newdata", nd_s[2], 128'd0);

    // Known-answer vector on all lane counts at once.
    kat_in = {16{8'h63}};
    kat_in[7:0] = 8'h1A; kat_in[15:8] = 8'h63; kat_in[23:16] = 8'h16;
    kat_in[31:24] = 8'h92; kat_in[39:32] = 8'hEF;
    kat_exp = '0;
    kat_exp[7:0] = 8'h43; kat_exp[23:16] = 8'hFF;
    kat_exp[31:24] = 8'h74; kat_exp[39:32] = 8'h61;
    olddata = kat_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("kat_busy", 128'(busy_s[2]), 128'd1);
    for (int i = 0; i < 5; i++) begin lat_s[i] = -1; cnt_s[i] = 0; end
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int i = 0; i < 5; i++) if (done_s[i]) begin
        cnt_s[i]++;
        if (lat_s[i] < 0) lat_s[i] = c;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("kat_lat_L%0d", 1 << i), 128'(lat_s[i]), 128'(16 >> i));
      chk($sformatf("kat_pulses_L%0d", 1 << i), 128'(cnt_s[i]), 128'd1);
      chk($sformatf("kat_data_L%0d", 1 << i), nd_s[i], kat_exp);
      chk($sformatf("kat_idle_busy_L%0d", 1 << i), 128'(busy_s[i]), 128'd0);
    end

    // Every byte value replicated across all lanes.
    for (int v = 0; v < 256; v++) begin
      d = {16{8'(v)}};
      xact(d, lat);
      chk("rt_lat", 128'(lat), 128'd4);
      chk("rt_data", nd_s[2], {16{inv_tab[v]}});
      chk("rt_fwd", 128'(fwd(nd_s[2][7:0])), 128'(v));
    end

    // Random states against the model.
    for (int n = 0; n < 30; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      xact(d, lat);
      chk("rand_lat", 128'(lat), 128'd4);
      chk("rand_data", nd_s[2], ref_inv(d));
    end

    // Back-to-back: start held high across DONE.
    rst = 1'b1; tick(); rst = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    olddata = a;
    start = 1'b1;
    tick();
    olddata = b;
    first = -1;
    second = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (first >= 0 && c == first + 1) start = 1'b0;
      if (done_s[2]) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (first >= 0 && second < 0) chk("b2b_hold", nd_s[2], ref_inv(a));
    end
    start = 1'b0;
    chk("b2b_first_lat", 128'(first), 128'd4);
    chk("b2b_gap", 128'(second - first), 128'd5);
    chk("b2b_second", nd_s[2], ref_inv(b));

    // start and olddata changes during RUN are ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    olddata = a;
    start = 1'b1;
    ndone = 0;
    tick();
    start = 1'b0;
    tick();
    if (done_s[2]) ndone++;
    olddata = ~a;
    start = 1'b1;
    tick();
    if (done_s[2]) ndone++;
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_s[2]) ndone++;
    end
    chk("ign_pulses", 128'(ndone), 128'd1);
    chk("ign_data", nd_s[2], ref_inv(a));

    // Reset in the second RUN cycle aborts the transform.
    d = {$urandom, $urandom, $urandom, $urandom};
    xact(d, lat);
    chk("pre_rst_data", nd_s[2], ref_inv(d));
    tick();
    olddata = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 128'(busy_s[2]), 128'd0);
    chk("abort_done", 128'(done_s[2]), 128'd0);
    chk("abort_newdata", nd_s[2], 128'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done_s[2]) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);

    // rst wins over start at the same edge.
    rst = 1'b1;
    start = 1'b1;
    olddata = {$urandom, $urandom, $urandom, $urandom};
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_over_start_busy", 128'(busy_s[2]), 128'd0);
    chk("rst_over_start_nd", nd_s[2], 128'd0);

    // First start after reset behaves normally.
    d = {$urandom, $urandom, $urandom, $urandom};
    xact(d, lat);
    chk("post_rst_lat", 128'(lat), 128'd4);
    chk("post_rst_data", nd_s[2], ref_inv(d));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
